// File: rtl/sdfa_neuron_driver.sv
`default_nettype none
// ============================================================================
// Module   : sdfa_neuron_driver
// Brief    : Initiator for an sdfa_neuron. Streams one block of (spike, weight)
//            beats into the neuron, collects its sum and forwards a thresholded
//            spike plus the raw sum downstream on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module sdfa_neuron_driver #(
    parameter int WEIGHT_W  = 9,
    parameter int SUM_W     = 10,
    parameter int BLOCK_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int THRESH    = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_spike,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic                cal_en,
    output logic                new_block,
    output logic                input_spike,
    output logic [WEIGHT_W-1:0] weight,
    input  logic [SUM_W-1:0]    sum,
    input  logic                cal_done,
    output logic                read_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_spike,
    output logic [SUM_W-1:0]    out_sum,
    output logic                err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FEED      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_OUT       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]        c_cnt_last = CNT_W'(BLOCK_LEN - 1);
    localparam logic [7:0]              c_tmo_last = 8'(TIMEOUT - 1);
    localparam logic signed [SUM_W-1:0] c_thresh   = SUM_W'(THRESH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_tmo;
    logic                r_in_ready;
    logic                r_cal_en;
    logic                r_new_block;
    logic                r_input_spike;
    logic [WEIGHT_W-1:0] r_weight;
    logic                r_read_done;
    logic                r_out_valid;
    logic                r_out_spike;
    logic [SUM_W-1:0]    r_out_sum;
    logic                r_err;

    logic w_beat;
    logic w_last;
    logic w_capture;
    logic w_timeout;

    assign w_beat    = in_valid && r_in_ready;
    assign w_last    = w_beat && (r_cnt == c_cnt_last);
    assign w_capture = (r_state == S_WAIT_DONE) && cal_done;
    // A cal_done on the expiry edge takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT_DONE) && !cal_done && (r_tmo == c_tmo_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_state_nxt = w_last ? S_WAIT_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (w_last) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (w_capture) begin
                    w_state_nxt = S_OUT;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // in_ready is registered from the next state so it reads 0 while in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_ready    <= 1'b0;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_cal_en      <= 1'b0;
            r_new_block   <= 1'b0;
            r_input_spike <= 1'b0;
            r_weight      <= '0;
            r_read_done   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_spike   <= 1'b0;
            r_out_sum     <= '0;
            r_err         <= 1'b0;
        end else begin
            r_in_ready    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FEED);
            r_cal_en      <= w_beat;
            r_new_block   <= w_beat && (r_cnt == '0);
            r_input_spike <= w_beat && in_spike;
            r_read_done   <= w_capture || w_timeout;

            if (w_beat) begin
                r_weight <= in_weight;
                r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            end

            if ((r_state == S_WAIT_DONE) && !cal_done && !w_timeout) begin
                r_tmo <= r_tmo + 8'd1;
            end else begin
                r_tmo <= '0;
            end

            if (w_capture) begin
                r_out_sum   <= sum;
                r_out_spike <= ($signed(sum) >= c_thresh);
                r_out_valid <= 1'b1;
            end else if ((r_state == S_OUT) && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign cal_en      = r_cal_en;
    assign new_block   = r_new_block;
    assign input_spike = r_input_spike;
    assign weight      = r_weight;
    assign read_done   = r_read_done;
    assign out_valid   = r_out_valid;
    assign out_spike   = r_out_spike;
    assign out_sum     = r_out_sum;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdfa_neuron_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdfa_neuron_driver
// Brief    : Self-checking bench with a behavioural neuron and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdfa_neuron_driver;

    localparam int WEIGHT_W  = 9;
    localparam int SUM_W     = 10;
    localparam int BLOCK_LEN = 4;
    localparam int CNT_W     = 5;
    localparam int THRESH    = 64;
    localparam int TIMEOUT   = 8;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_spike = 1'b0;
    logic [WEIGHT_W-1:0] in_weight = '0;
    logic                cal_en;
    logic                new_block;
    logic                input_spike;
    logic [WEIGHT_W-1:0] weight;
    logic [SUM_W-1:0]    sum;
    logic                cal_done;
    logic                read_done;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic                out_spike;
    logic [SUM_W-1:0]    out_sum;
    logic                err;

    always #5 clk = ~clk;

    sdfa_neuron_driver #(
        .WEIGHT_W (WEIGHT_W),
        .SUM_W    (SUM_W),
        .BLOCK_LEN(BLOCK_LEN),
        .CNT_W    (CNT_W),
        .THRESH   (THRESH),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_spike   (in_spike),
        .in_weight  (in_weight),
        .cal_en     (cal_en),
        .new_block  (new_block),
        .input_spike(input_spike),
        .weight     (weight),
        .sum        (sum),
        .cal_done   (cal_done),
        .read_done  (read_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_spike  (out_spike),
        .out_sum    (out_sum),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural neuron: accumulates spike*weight, raises cal_done a few
    // cycles after the BLOCK_LEN-th beat and holds it until read_done.
    logic signed [SUM_W-1:0] nrn_acc;
    int                      nrn_cnt;
    logic                    nrn_pend;
    int                      nrn_dly;
    bit                      nrn_en = 1'b1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nrn_acc  <= '0;
            nrn_cnt  <= 0;
            nrn_pend <= 1'b0;
            nrn_dly  <= 0;
            cal_done <= 1'b0;
        end else begin
            if (cal_en) begin
                nrn_acc <= (new_block ? '0 : nrn_acc) +
                           (input_spike ? {weight[WEIGHT_W-1], weight} : '0);
                nrn_cnt <= new_block ? 1 : nrn_cnt + 1;
                if ((new_block ? 1 : nrn_cnt + 1) == BLOCK_LEN) begin
                    nrn_pend <= 1'b1;
                    nrn_dly  <= 0;
                end
            end
            if (nrn_pend && !cal_done) begin
                if (nrn_dly >= 2 && nrn_en) cal_done <= 1'b1;
                nrn_dly <= nrn_dly + 1;
            end
            if (read_done) begin
                cal_done <= 1'b0;
                nrn_pend <= 1'b0;
            end
        end
    end
    assign sum = nrn_acc;

    typedef struct packed {
        logic             spike;
        logic [SUM_W-1:0] sum;
    } res_t;
    res_t sb_q[$];

    int   ce_cnt = 0, nb_cnt = 0, rd_cnt = 0, ov_cnt = 0;
    int   spk_gap = 0, rd_long = 0, nb_pos = -1;
    logic rd_prev = 1'b0;

    // Monitor samples 1ns after the falling edge, after the driver has settled inputs.
    always begin
        @(negedge clk);
        #1;
        if (new_block) begin
            nb_cnt++;
            nb_pos = ce_cnt;
        end
        if (cal_en) ce_cnt++;
        if (!cal_en && input_spike) spk_gap++;
        if (read_done) rd_cnt++;
        if (read_done && rd_prev) rd_long++;
        rd_prev = read_done;
        if (out_valid && out_ready) begin
            ov_cnt++;
            check_val("sb_has_expect", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                res_t e;
                e = sb_q.pop_front();
                check_val("out_sum", out_sum, e.sum);
                check_val("out_spike", out_spike, e.spike);
            end
        end
    end

    task automatic send_beat(input logic s, input logic [WEIGHT_W-1:0] w);
        int t;
        t = 0;
        in_valid  = 1'b1;
        in_spike  = s;
        in_weight = w;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("beat_accept_bound", (t < 100), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_spike = 1'b0;
    endtask

    task automatic send_block(input logic [3:0] s, input int w0, input int w1,
                              input int w2, input int w3, input int gap, input bit push);
        int               w[4];
        logic [SUM_W-1:0] acc;
        res_t             e;
        w   = '{w0, w1, w2, w3};
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) acc = acc + SUM_W'(w[i]);
            send_beat(s[i], WEIGHT_W'(w[i]));
            if (i == 1 && gap > 0) repeat (gap) @(negedge clk);
        end
        e.sum   = acc;
        e.spike = ($signed(acc) >= 10'sd64);
        if (push) sb_q.push_back(e);
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("result_bound", (t < 200), 1);
        repeat (2) @(negedge clk);
    endtask

    int ce0, nb0, rd0, ov0, t;
    res_t e4;

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  {in_ready, cal_en, new_block, input_spike, weight,
                   read_done, out_valid, out_spike, out_sum, err}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_in_ready", in_ready, 1);

        // Back-to-back block, sum 10
        ce0 = ce_cnt; nb0 = nb_cnt; rd0 = rd_cnt;
        send_block(4'b1111, 1, 2, 3, 4, 0, 1);
        wait_result();
        check_val("t1_cal_en_cycles", ce_cnt - ce0, 4);
        check_val("t1_new_block_cnt", nb_cnt - nb0, 1);
        check_val("t1_new_block_pos", nb_pos, ce0);
        check_val("t1_read_done_cnt", rd_cnt - rd0, 1);
        check_val("t1_read_done_len", rd_long, 0);

        // Threshold cases: 70, -64, exactly 64, sparse spikes
        send_block(4'b1111, 20, 20, 20, 10, 0, 1);
        wait_result();
        send_block(4'b1111, -16, -16, -16, -16, 0, 1);
        wait_result();
        send_block(4'b1111, 16, 16, 16, 16, 0, 1);
        wait_result();
        send_block(4'b0101, 100, 50, 30, 7, 0, 1);
        wait_result();

        // Bubbles between beats 2 and 3
        ce0 = ce_cnt; nb0 = nb_cnt; t = spk_gap;
        send_block(4'b1111, 5, 6, 7, 8, 3, 1);
        wait_result();
        check_val("t3_cal_en_cycles", ce_cnt - ce0, 4);
        check_val("t3_new_block_cnt", nb_cnt - nb0, 1);
        check_val("t3_spike_in_gap", spk_gap - t, 0);

        // Downstream back-pressure with a beat waiting upstream
        out_ready = 1'b0;
        send_block(4'b1111, 5, 5, 5, 5, 0, 1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("t4_out_valid", out_valid, 1);
        in_valid = 1'b1; in_spike = 1'b1; in_weight = 9'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t4_hold_valid", out_valid, 1);
            check_val("t4_hold_sum", out_sum, 20);
            check_val("t4_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val("t4_in_ready_back", in_ready, 1);
        check_val("t4_beat_not_taken", cal_en, 0);
        @(negedge clk);
        check_val("t4_beat_taken", cal_en, 1);
        check_val("t4_beat_new_block", new_block, 1);
        for (int i = 0; i < 3; i++) send_beat(1'b1, 9'd3);
        e4.sum = 10'd12; e4.spike = 1'b0;
        sb_q.push_back(e4);
        wait_result();

        // cal_done never arrives
        nrn_en = 1'b0;
        rd0 = rd_cnt; ov0 = ov_cnt;
        send_block(4'b1111, 1, 1, 1, 1, 0, 0);
        t = 0;
        while (!err && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val("t5_err_latency", t, 8);
        check_val("t5_err", err, 1);
        check_val("t5_in_ready", in_ready, 1);
        repeat (4) @(negedge clk);
        check_val("t5_read_done_cnt", rd_cnt - rd0, 1);
        check_val("t5_no_out_valid", ov_cnt - ov0, 0);
        nrn_en = 1'b1;
        send_block(4'b1111, 30, 30, 30, 30, 0, 1);
        wait_result();
        check_val("t5_err_sticky", err, 1);

        // Asynchronous reset mid-block
        send_beat(1'b1, 9'd5);
        send_beat(1'b1, 9'd6);
        rstn = 1'b0;
        #1;
        check_val("t6_async_outputs",
                  {in_ready, cal_en, new_block, input_spike, weight,
                   read_done, out_valid, out_spike, out_sum, err}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        ce0 = ce_cnt; nb0 = nb_cnt;
        send_block(4'b1111, 7, 8, 9, 10, 0, 1);
        wait_result();
        check_val("t6_new_block_cnt", nb_cnt - nb0, 1);
        check_val("t6_new_block_pos", nb_pos, ce0);
        check_val("t6_cal_en_cycles", ce_cnt - ce0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
